// File: rtl/text_buf_writer.sv
// text_buf_writer: ASCII stream to 16x16 character RAM with cursor,
// control codes, clear sweeps and a registered read port.
module text_buf_writer #(
  parameter int         COLS  = 16,
  parameter int         ROWS  = 16,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  output logic [7:0] cursor_xy,
  output logic       busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int DEPTH = COLS * ROWS;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_LINE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    sweep_q, sweep_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [6:0]    char_code_q, char_code_d;

  logic [6:0]    mem_q [DEPTH];

  logic          we;
  logic [7:0]    waddr;
  logic [6:0]    wdata;

  logic          accept;
  logic          is_print;
  logic          is_lf;
  logic          is_cr;
  logic          is_bs;
  logic          is_ff;

  assign in_ready  = (state_q == IDLE);
  assign busy      = !in_ready;
  assign cursor_xy = {row_q, col_q};
  assign char_code = char_code_q;
  assign accept    = in_valid && in_ready;

  // Classify the incoming byte; anything unmatched is dropped.
  always_comb begin
    is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
    is_lf    = (in_data == 8'h0A);
    is_cr    = (in_data == 8'h0D);
    is_bs    = (in_data == 8'h08);
    is_ff    = (in_data == 8'h0C);
  end

  // Next state, sweep counter, cursor and the single RAM write port.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    row_d   = row_q;
    col_d   = col_q;
    we      = 1'b0;
    waddr   = {row_q, col_q};
    wdata   = BLANK;
    unique case (state_q)
      CLR_ALL: begin
        we      = 1'b1;
        waddr   = sweep_q;
        sweep_d = sweep_q + 8'd1;
        if (sweep_q == 8'(DEPTH - 1)) begin
          state_d = IDLE;
          sweep_d = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      CLR_LINE: begin
        we      = 1'b1;
        waddr   = {row_q, sweep_q[CW-1:0]};
        sweep_d = sweep_q + 8'd1;
        if (sweep_q[CW-1:0] == CW'(COLS - 1)) begin
          state_d = IDLE;
          sweep_d = '0;
        end
      end
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_print: begin
              we    = 1'b1;
              wdata = in_data[6:0];
              if (col_q == CW'(COLS - 1)) begin
                col_d   = '0;
                row_d   = row_q + RW'(1);
                sweep_d = '0;
                state_d = CLR_LINE;
              end else begin
                col_d = col_q + CW'(1);
              end
            end
            is_lf: begin
              col_d   = '0;
              row_d   = row_q + RW'(1);
              sweep_d = '0;
              state_d = CLR_LINE;
            end
            is_cr: begin
              col_d = '0;
            end
            is_bs: begin
              if (col_q != '0) begin
                col_d = col_q - CW'(1);
                we    = 1'b1;
                waddr = {row_q, col_q - CW'(1)};
                wdata = BLANK;
              end
            end
            is_ff: begin
              sweep_d = '0;
              state_d = CLR_ALL;
            end
            default: begin
            end
          endcase
        end
      end
      default: begin
        state_d = CLR_ALL;
        sweep_d = '0;
      end
    endcase
  end

  // Read port samples the RAM before this edge's write lands.
  always_comb begin
    char_code_d = mem_q[char_xy];
  end

  // Control state; reset restarts the full clear sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLR_ALL;
      sweep_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      char_code_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      row_q       <= row_d;
      col_q       <= col_d;
      char_code_q <= char_code_d;
    end
  end

  // Character RAM; contents are defined by the clear sweep, not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_text_buf_writer.sv
// tb_text_buf_writer: table vectors plus read scoreboard against a
// behavioural model of the character buffer and cursor.
module tb_text_buf_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic [7:0] cursor_xy;
  logic       busy;

  text_buf_writer dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .char_xy(char_xy),
    .char_code(char_code),
    .cursor_xy(cursor_xy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] exp_mem [256];
  logic [3:0] mrow;
  logic [3:0] mcol;
  logic [6:0] sb_q [$];

  typedef struct {
    logic [7:0] b;
    logic [7:0] cur;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear_all();
    for (int a = 0; a < 256; a++) exp_mem[a] = 7'h20;
    mrow = '0;
    mcol = '0;
  endtask

  task automatic model_advance();
    mcol = '0;
    mrow = mrow + 4'd1;
    for (int c = 0; c < 16; c++) exp_mem[{mrow, 4'(c)}] = 7'h20;
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_mem[{mrow, mcol}] = b[6:0];
      if (mcol == 4'd15) model_advance();
      else mcol = mcol + 4'd1;
    end else if (b == 8'h0A) begin
      model_advance();
    end else if (b == 8'h0D) begin
      mcol = '0;
    end else if (b == 8'h08) begin
      if (mcol != 4'd0) begin
        mcol = mcol - 4'd1;
        exp_mem[{mrow, mcol}] = 7'h20;
      end
    end else if (b == 8'h0C) begin
      model_clear_all();
    end
  endtask

  task automatic rd(input logic [7:0] a, input string nm);
    logic [6:0] e;
    @(negedge clk);
    char_xy = a;
    sb_q.push_back(exp_mem[a]);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk($sformatf("%s[%02h]", nm, a), char_code, e);
  endtask

  task automatic check_all(input string nm);
    for (int a = 0; a < 256; a++) rd(8'(a), nm);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: byte %02h never accepted", b);
      return;
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_apply(b);
  endtask

  task automatic wait_ready(input int exp, input string nm);
    int n = 0;
    while (!in_ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, n, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{8'h41, 8'h01};
    tbl[1]  = '{8'h90, 8'h01};
    tbl[2]  = '{8'h58, 8'h02};
    tbl[3]  = '{8'h42, 8'h03};
    tbl[4]  = '{8'h08, 8'h02};
    tbl[5]  = '{8'h08, 8'h01};
    tbl[6]  = '{8'h08, 8'h00};
    tbl[7]  = '{8'h08, 8'h00};
    tbl[8]  = '{8'h31, 8'h01};
    tbl[9]  = '{8'h32, 8'h02};
    tbl[10] = '{8'h33, 8'h03};
    tbl[11] = '{8'h34, 8'h04};
    tbl[12] = '{8'h35, 8'h05};
    tbl[13] = '{8'h36, 8'h06};
    tbl[14] = '{8'h37, 8'h07};
    tbl[15] = '{8'h0D, 8'h00};
    tbl[16] = '{8'h1B, 8'h00};
    tbl[17] = '{8'h7F, 8'h00};
    tbl[18] = '{8'h7E, 8'h01};
    tbl[19] = '{8'h0D, 8'h00};

    rst      = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    char_xy  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_cursor", cursor_xy, 8'h00);
    chk("rst_char_code", char_code, 7'h00);

    @(negedge clk);
    rst = 1'b1;
    model_clear_all();
    wait_ready(256, "clr_all_cycles");
    chk("post_clr_cursor", cursor_xy, 8'h00);
    chk("post_clr_busy", busy, 0);
    check_all("blank_init");

    for (int i = 0; i < 20; i++) begin
      send(tbl[i].b);
      chk($sformatf("tbl%0d_cursor", i), cursor_xy, tbl[i].cur);
      chk($sformatf("tbl%0d_ready", i), in_ready, 1);
    end
    check_all("after_table");

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b_ready%0d", i), in_ready, 1);
      in_data  = 8'h50 + 8'(i);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      model_apply(in_data);
      if (i == 15) in_valid = 1'b0;
      else @(negedge clk);
    end
    chk("b2b_cursor", cursor_xy, 8'h10);
    chk("b2b_busy", in_ready, 0);
    wait_ready(16, "b2b_clr_line_cycles");
    check_all("after_b2b");

    for (int i = 0; i < 14; i++) begin
      send(8'h0A);
      wait_ready(16, "lf_clr_line_cycles");
    end
    chk("lf_row15_cursor", cursor_xy, 8'hF0);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    chk("row15_cursor", cursor_xy, 8'hF5);
    send(8'h0A);
    chk("lf_wrap_cursor", cursor_xy, 8'h00);
    wait_ready(16, "lf_wrap_cycles");
    check_all("after_lf_wrap");

    send(8'h48);
    send(8'h69);
    send(8'h0C);
    chk("ff_busy", busy, 1);
    wait_ready(256, "ff_cycles");
    chk("ff_cursor", cursor_xy, 8'h00);
    check_all("after_ff");

    @(negedge clk);
    chk("rdw_ready", in_ready, 1);
    char_xy  = 8'h00;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    sb_q.push_back(exp_mem[0]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rdw_old", char_code, sb_q.pop_front());
    model_apply(8'h5A);
    @(negedge clk);
    sb_q.push_back(exp_mem[0]);
    @(posedge clk);
    #1;
    chk("rdw_new", char_code, sb_q.pop_front());

    send(8'h0A);
    chk("mid_lf_cursor", cursor_xy, 8'h10);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_cursor", cursor_xy, 8'h00);
    chk("mid_rst_char_code", char_code, 7'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear_all();
    wait_ready(256, "re_clr_all_cycles");
    chk("re_clr_cursor", cursor_xy, 8'h00);
    check_all("after_re_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
